qspi_mem_arbiter: RTL

Round-robin arbiter that shares the single QSPI XIP memory port between up to NUM_REQ FazyRV cores inside hachure_soc. Each core presents a classic Wishbone-style single-beat request; the arbiter serializes them onto one downstream memory port feeding the QSPI controller. It also returns read data and a per-requester ack or error. A watchdog aborts bus cycles whose memory ack never arrives.

---
 rtl/qspi_mem_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/qspi_mem_arbiter.sv
// Round-robin arbiter sharing one QSPI XIP memory port among NUM_REQ Wishbone-style requesters.
// Latency: grant+mem_cyc 1 cycle after request, ack 1 cycle after mem_ack; requesters wait (hold cyc) until acked, watchdog aborts hung cycles.
module qspi_mem_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        en_i,
    input  logic [NUM_REQ-1:0]        req_cyc_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*AW-1:0]     req_adr_i,
    input  logic [NUM_REQ*DW-1:0]     req_dat_i,
    input  logic [NUM_REQ*DW/8-1:0]   req_sel_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [NUM_REQ-1:0]        req_err_o,
    output logic [DW-1:0]             req_dat_o,
    output logic                      mem_cyc_o,
    output logic                      mem_we_o,
    output logic [AW-1:0]             mem_adr_o,
    output logic [DW-1:0]             mem_dat_o,
    output logic [DW/8-1:0]           mem_sel_o,
    input  logic                      mem_ack_i,
    input  logic [DW-1:0]             mem_dat_i,
    output logic [NUM_REQ-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      last_q, last_d;
    logic [LW-1:0]      owner_q, owner_d;
    logic [WW-1:0]      wdog_q, wdog_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic [SW-1:0]      sel_q, sel_d;

    logic [NUM_REQ-1:0] elig;
    logic               win_vld;
    logic [LW-1:0]      win_idx;
    logic [WW-1:0]      wdog_inc;

    assign elig     = req_cyc_i & en_i;
    assign wdog_inc = wdog_q + 1'b1;

    // Scan from furthest to nearest so the closest eligible index after last_q wins.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (elig[idx]) begin
                win_vld = 1'b1;
                win_idx = LW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        wdog_d  = wdog_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    we_d    = req_we_i[win_idx];
                    adr_d   = req_adr_i[int'(win_idx)*AW +: AW];
                    dat_d   = req_dat_i[int'(win_idx)*DW +: DW];
                    sel_d   = req_sel_i[int'(win_idx)*SW +: SW];
                    cyc_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // A memory ack in the final watchdog cycle still counts as success.
                if (mem_ack_i) begin
                    rdata_d = mem_dat_i;
                    ack_d   = grant_q;
                    err_d   = '0;
                    cyc_d   = 1'b0;
                    state_d = DONE;
                end else if (wdog_inc == WW'(TIMEOUT)) begin
                    wdog_d  = wdog_inc;
                    rdata_d = '0;
                    ack_d   = grant_q;
                    err_d   = grant_q;
                    cyc_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    wdog_d  = wdog_inc;
                end
            end
            DONE: begin
                ack_d   = '0;
                err_d   = '0;
                rdata_d = '0;
                last_d  = owner_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= LW'(NUM_REQ - 1);
            owner_q <= '0;
            wdog_q  <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            wdog_q  <= wdog_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    assign req_ack_o = ack_q;
    assign req_err_o = err_q;
    assign req_dat_o = rdata_q;
    assign mem_cyc_o = cyc_q;
    assign mem_we_o  = we_q;
    assign mem_adr_o = adr_q;
    assign mem_dat_o = dat_q;
    assign mem_sel_o = sel_q;
    assign grant_o   = grant_q;

endmodule
